// File: rtl/feeder_b_loader.sv
// B-matrix feeder loader: streams cache-line reads for consecutive workloads into a
// credit-limited response FIFO and pumps the lines into the feeder bank, pausing at workload ends.
module feeder_b_loader #(
  parameter int NUM_COL    = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_W     = 42
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_blocks,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_req_ready,
  input  logic              rd_rsp_valid,
  input  logic [511:0]      rd_rsp_data,
  input  logic              feeder_full,
  output logic              feeder_wr_en,
  output logic [511:0]      feeder_data,
  output logic              busy,
  output logic              done
);

  localparam int LPB = NUM_COL * 256;
  localparam int LW  = $clog2(LPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [LW-1:0] LAST_LINE = LW'(LPB - 1);
  localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PM_PUMP = 2'd0,
    PM_GAP  = 2'd1,
    PM_WAIT = 2'd2
  } pump_t;

  state_t            state_r;
  pump_t             pump_r;
  logic              gap_cnt_r;
  logic [LW-1:0]     line_cnt_r;
  logic [15:0]       blk_cnt_r;
  logic [15:0]       nblk_r;
  logic [25:0]       total_r;
  logic [25:0]       req_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [CW-1:0]     outst_r;
  logic [CW-1:0]     cnt_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [511:0]      mem_r [FIFO_DEPTH];
  logic              wr_en_r;
  logic [511:0]      data_r;
  logic              busy_r;
  logic              done_r;
  logic              fin_r;

  logic [CW:0]       credit_sum_s;
  logic              req_valid_s;
  logic              accept_s;
  logic              push_s;
  logic              pop_s;
  logic              pump_open_s;
  logic              last_line_s;
  logic              last_blk_s;

  // Credit, handshake and FIFO push/pop decisions derived from registered state.
  always_comb begin
    credit_sum_s = {1'b0, outst_r} + {1'b0, cnt_r};
    req_valid_s  = (state_r == ST_RUN) && (credit_sum_s < DEPTH_C);
    accept_s     = req_valid_s && rd_req_ready;
    // Responses with nothing outstanding are leftovers from before a reset.
    push_s       = rd_rsp_valid && (outst_r != {CW{1'b0}});
    pump_open_s  = (pump_r == PM_PUMP) || ((pump_r == PM_WAIT) && !feeder_full);
    pop_s        = ((state_r == ST_RUN) || (state_r == ST_DRAIN)) && (cnt_r != {CW{1'b0}})
                   && pump_open_s && !fin_r;
    last_line_s  = (line_cnt_r == LAST_LINE);
    last_blk_s   = (blk_cnt_r == (nblk_r - 16'd1));
  end

  // Response line storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= rd_rsp_data;
    end
  end

  // Control FSM, request generator, FIFO bookkeeping and write pump.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      pump_r     <= PM_PUMP;
      gap_cnt_r  <= 1'b0;
      line_cnt_r <= {LW{1'b0}};
      blk_cnt_r  <= 16'd0;
      nblk_r     <= 16'd0;
      total_r    <= 26'd0;
      req_cnt_r  <= 26'd0;
      addr_r     <= {ADDR_W{1'b0}};
      outst_r    <= {CW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      wr_en_r    <= 1'b0;
      data_r     <= 512'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      fin_r      <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      wr_en_r <= pop_s;
      if (pop_s) begin
        data_r   <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      cnt_r   <= cnt_r + CW'(push_s) - CW'(pop_s);
      outst_r <= outst_r + CW'(accept_s) - CW'(push_s);
      if (accept_s) begin
        addr_r    <= addr_r + ADDR_W'(1);
        req_cnt_r <= req_cnt_r + 26'd1;
      end

      // Two GAP cycles let the feeder's count and registered full flag settle before sampling.
      if (pop_s) begin
        if (last_line_s) begin
          line_cnt_r <= {LW{1'b0}};
          if (last_blk_s) begin
            fin_r <= 1'b1;
          end else begin
            blk_cnt_r <= blk_cnt_r + 16'd1;
            pump_r    <= PM_GAP;
            gap_cnt_r <= 1'b0;
          end
        end else begin
          line_cnt_r <= line_cnt_r + LW'(1);
          pump_r     <= PM_PUMP;
        end
      end else begin
        case (pump_r)
          PM_PUMP: pump_r <= PM_PUMP;
          PM_GAP: begin
            if (gap_cnt_r) begin
              pump_r <= PM_WAIT;
            end else begin
              gap_cnt_r <= 1'b1;
            end
          end
          PM_WAIT: begin
            if (!feeder_full) begin
              pump_r <= PM_PUMP;
            end
          end
          default: pump_r <= PM_PUMP;
        endcase
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            addr_r     <= base_addr;
            nblk_r     <= num_blocks;
            total_r    <= 26'(num_blocks) * 26'(LPB);
            req_cnt_r  <= 26'd0;
            blk_cnt_r  <= 16'd0;
            line_cnt_r <= {LW{1'b0}};
            pump_r     <= PM_PUMP;
            fin_r      <= 1'b0;
            if (num_blocks == 16'd0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept_s && (req_cnt_r == (total_r - 26'd1))) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // fin_r is set on the last pop, so this fires the cycle that line reaches the feeder.
          if (fin_r) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            fin_r   <= 1'b0;
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign rd_req_valid = req_valid_s;
  assign rd_req_addr  = addr_r;
  assign feeder_wr_en = wr_en_r;
  assign feeder_data  = data_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_feeder_b_loader.sv
// Directed bench for feeder_b_loader: a host responder with fixed latency, a feeder-full
// stimulus and an address-order scoreboard, all checked through check_eq.
module tb_feeder_b_loader;

  localparam int NUM_COL    = 2;
  localparam int FIFO_DEPTH = 64;
  localparam int ADDR_W     = 42;
  localparam int LPB        = NUM_COL * 256;

  logic              clk          = 1'b0;
  logic              reset        = 1'b0;
  logic              start        = 1'b0;
  logic [ADDR_W-1:0] base_addr    = '0;
  logic [15:0]       num_blocks   = 16'd0;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_ready = 1'b1;
  logic              rd_rsp_valid = 1'b0;
  logic [511:0]      rd_rsp_data  = '0;
  logic              feeder_full  = 1'b0;
  logic              feeder_wr_en;
  logic [511:0]      feeder_data;
  logic              busy;
  logic              done;

  feeder_b_loader #(.NUM_COL(NUM_COL), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_blocks(num_blocks),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .feeder_full(feeder_full),
    .feeder_wr_en(feeder_wr_en), .feeder_data(feeder_data), .busy(busy), .done(done)
  );

  typedef struct {
    int                due;
    logic [ADDR_W-1:0] addr;
  } rsp_t;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  rsp_t rsp_q[$];
  int rsp_lat = 4;
  bit rand_ready = 1'b0;
  logic [ADDR_W-1:0] exp_req_addr, exp_wr_addr, prev_addr;
  int acc_cnt, wr_cnt, done_cnt, valid_cyc, busy_cyc, done_cyc, last_wr_cyc, start_cyc;
  int gap1, gap2, full_trig, full_left;
  bit prev_valid = 1'b0;
  bit prev_ready = 1'b0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_clear(input logic [ADDR_W-1:0] base);
    exp_req_addr = base;
    exp_wr_addr  = base;
    acc_cnt = 0; wr_cnt = 0; done_cnt = 0; valid_cyc = 0; busy_cyc = 0;
    done_cyc = 0; last_wr_cyc = 0; gap1 = 0; gap2 = 0; full_trig = 0; full_left = 0;
  endtask

  task automatic bfm_step();
    rsp_t r;
    if (feeder_wr_en) begin
      check_eq("wr_data", feeder_data, 512'(exp_wr_addr));
      if (wr_cnt == LPB && gap1 != 0) check_eq("gap_blk1", 512'(cyc - last_wr_cyc), 512'(gap1));
      if (wr_cnt == 2 * LPB && gap2 != 0) check_eq("gap_blk2", 512'(cyc - last_wr_cyc), 512'(gap2));
      exp_wr_addr = exp_wr_addr + 42'd1;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (done) begin
      check_eq("busy_at_done", 512'(busy), 512'(1'b0));
      done_cnt++;
      done_cyc = cyc;
    end
    if (rd_req_valid) valid_cyc++;
    if (busy) busy_cyc++;
    if (full_left != 0) begin
      full_left--;
      if (full_left == 0) feeder_full = 1'b0;
    end else if (full_trig != 0 && feeder_wr_en && wr_cnt == full_trig) begin
      feeder_full = 1'b1;
      full_left   = 50;
    end
    if (prev_valid && !prev_ready) begin
      check_eq("req_hold_valid", 512'(rd_req_valid), 512'(1'b1));
      check_eq("req_hold_addr", 512'(rd_req_addr), 512'(prev_addr));
    end
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = 512'(r.addr);
    end
    rd_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (rd_req_valid && rd_req_ready) begin
      check_eq("req_addr", 512'(rd_req_addr), 512'(exp_req_addr));
      check_eq("credit", 512'((acc_cnt - wr_cnt) < FIFO_DEPTH), 512'(1'b1));
      r.due  = cyc + rsp_lat;
      r.addr = rd_req_addr;
      rsp_q.push_back(r);
      exp_req_addr = exp_req_addr + 42'd1;
      acc_cnt++;
    end
    prev_valid = rd_req_valid;
    prev_ready = rd_req_ready;
    prev_addr  = rd_req_addr;
  endtask

  task automatic run_start(input logic [ADDR_W-1:0] base, input logic [15:0] nb);
    @(negedge clk);
    start = 1'b1; base_addr = base; num_blocks = nb; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 512'(done_cnt != 0), 512'(1'b1));
    repeat (5) @(negedge clk);
  endtask

  task automatic check_single(input string tag, input int nwr);
    check_eq({tag, "_writes"}, 512'(wr_cnt), 512'(nwr));
    check_eq({tag, "_reqs"}, 512'(acc_cnt), 512'(nwr));
    check_eq({tag, "_done_cnt"}, 512'(done_cnt), 512'(1));
    check_eq({tag, "_done_lat"}, 512'(done_cyc - last_wr_cyc), 512'(1));
    check_eq({tag, "_busy_cyc"}, 512'(busy_cyc), 512'(done_cyc - start_cyc - 1));
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin @(negedge clk); bfm_step(); end

  initial begin
    sb_clear('0);
    #12;
    check_eq("rst_valid", 512'(rd_req_valid), 512'(1'b0));
    check_eq("rst_wr_en", 512'(feeder_wr_en), 512'(1'b0));
    check_eq("rst_busy", 512'(busy), 512'(1'b0));
    check_eq("rst_done", 512'(done), 512'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // single workload, addresses 0x100..0x2FF
    sb_clear(42'h100);
    run_start(42'h100, 16'd1);
    wait_done(3000, "s1_timeout");
    check_single("s1", LPB);
    check_eq("s1_last_addr", 512'(exp_wr_addr), 512'(42'h300));

    // three workloads, feeder full for 50 cycles at the second boundary
    sb_clear(42'h1000);
    gap1 = 3; gap2 = 51; full_trig = 2 * LPB;
    run_start(42'h1000, 16'd3);
    wait_done(6000, "s2_timeout");
    check_single("s2", 3 * LPB);

    // random ready, 40-cycle latency, address wrap at 2^42
    sb_clear(42'h3FF_FFFF_FF00);
    rsp_lat = 40; rand_ready = 1'b1;
    run_start(42'h3FF_FFFF_FF00, 16'd1);
    wait_done(8000, "s3_timeout");
    check_single("s3", LPB);
    check_eq("s3_wrapped_addr", 512'(exp_wr_addr), 512'(42'h100));
    rsp_lat = 4; rand_ready = 1'b0;
    repeat (50) @(negedge clk);

    // zero workloads
    sb_clear(42'h40);
    run_start(42'h40, 16'd0);
    wait_done(20, "s4_timeout");
    check_eq("s4_done_lat", 512'(done_cyc - start_cyc), 512'(1));
    check_eq("s4_done_cnt", 512'(done_cnt), 512'(1));
    check_eq("s4_no_valid", 512'(valid_cyc), 512'(0));
    check_eq("s4_no_busy", 512'(busy_cyc), 512'(0));

    // reset in the middle of the second workload, then restart
    sb_clear(42'h8000);
    run_start(42'h8000, 16'd2);
    begin
      int n = 0;
      while (wr_cnt < 700 && n < 3000) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("s5_reach_700", 512'(wr_cnt >= 700), 512'(1'b1));
    #2 reset = 1'b0;
    prev_valid = 1'b0;
    #1;
    check_eq("s5_rst_valid", 512'(rd_req_valid), 512'(1'b0));
    check_eq("s5_rst_addr", 512'(rd_req_addr), 512'(0));
    check_eq("s5_rst_wr_en", 512'(feeder_wr_en), 512'(1'b0));
    check_eq("s5_rst_data", feeder_data, 512'(0));
    check_eq("s5_rst_busy", 512'(busy), 512'(1'b0));
    check_eq("s5_rst_done", 512'(done), 512'(1'b0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    sb_clear(42'h100);
    run_start(42'h100, 16'd1);
    wait_done(3000, "s5_timeout");
    check_single("s5", LPB);

    // start pulsed while busy with different parameters
    sb_clear(42'h100);
    run_start(42'h100, 16'd1);
    repeat (100) @(negedge clk);
    start = 1'b1; base_addr = 42'h5000; num_blocks = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(3000, "s6_timeout");
    repeat (20) @(negedge clk);
    check_single("s6", LPB);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
